// File: rtl/cm0_dap_cdc_send_ctl.sv
// cm0_dap_cdc_send_ctl: sender-side 4-phase REQ/ACK sequencer driving a glitch-free CDC data mask
module cm0_dap_cdc_send_ctl #(
  parameter int PRESENT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        DCLK,
  input  logic        DRESET,
  input  logic [31:0] WDATA,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [31:0] CDCDATA,
  output logic        CDCMASKn,
  output logic        CDCREQ,
  input  logic        CDCACK,
  output logic        BUSY
);
  if (PRESENT != 0) begin : g_on
    // bit 3 is the mask enable and bit 2 the request, so both leave the block straight from a flop
    typedef enum logic [3:0] {
      IDLE = 4'b0000,
      LOAD = 4'b0001,
      OPEN = 4'b1000,
      REQ  = 4'b1100,
      RTZ  = 4'b0010
    } state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] ack_q;
    logic [31:0] data_q;
    logic ack_s;
    assign ack_s = ack_q[SYNC_STAGES-1];
    always_ff @(posedge DCLK) begin
      if (DRESET) begin
        state  <= IDLE;
        ack_q  <= '0;
        data_q <= '0;
      end else begin
        state <= state_nxt;
        ack_q <= {ack_q[SYNC_STAGES-2:0], CDCACK};
        if (WVALID && state == IDLE) data_q <= WDATA;
      end
    end
    always_comb begin
      state_nxt = IDLE;
      case (state)
        IDLE:    state_nxt = WVALID ? LOAD : IDLE;
        LOAD:    state_nxt = OPEN;
        OPEN:    state_nxt = REQ;
        REQ:     state_nxt = ack_s ? RTZ : REQ;
        RTZ:     state_nxt = ack_s ? RTZ : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    assign WREADY   = state == IDLE;
    assign BUSY     = state != IDLE;
    assign CDCDATA  = data_q;
    assign CDCMASKn = state[3];
    assign CDCREQ   = state[2];
  end else begin : g_off
    assign WREADY   = 1'b1;
    assign BUSY     = 1'b0;
    assign CDCDATA  = '0;
    assign CDCMASKn = 1'b0;
    assign CDCREQ   = 1'b0;
  end
endmodule

// File: tb/tb_cm0_dap_cdc_send_ctl.sv
// tb_cm0_dap_cdc_send_ctl: scoreboarded directed bench for the CDC send sequencer
module tb_cm0_dap_cdc_send_ctl;
  logic DCLK = 1'b0, DRESET = 1'b1, WVALID = 1'b0, CDCACK = 1'b0;
  logic [31:0] WDATA = '0;
  logic WREADY, CDCMASKn, CDCREQ, BUSY;
  logic [31:0] CDCDATA;
  logic off_rdy, off_mask, off_req, off_busy;
  logic [31:0] off_data;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic rst_seen = 1'b1, prev_mask = 1'b0, prev_req = 1'b0;
  logic [31:0] prev_data = '0;

  cm0_dap_cdc_send_ctl #(.PRESENT(1), .SYNC_STAGES(2)) dut (
    .DCLK(DCLK), .DRESET(DRESET), .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .CDCDATA(CDCDATA), .CDCMASKn(CDCMASKn), .CDCREQ(CDCREQ), .CDCACK(CDCACK), .BUSY(BUSY)
  );
  cm0_dap_cdc_send_ctl #(.PRESENT(0), .SYNC_STAGES(2)) u_off (
    .DCLK(DCLK), .DRESET(DRESET), .WDATA(WDATA), .WVALID(WVALID), .WREADY(off_rdy),
    .CDCDATA(off_data), .CDCMASKn(off_mask), .CDCREQ(off_req), .CDCACK(CDCACK), .BUSY(off_busy)
  );

  always #5 DCLK = ~DCLK;
  always @(posedge DCLK) rst_seen <= DRESET;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge DCLK);
  endtask

  // {CDCMASKn, CDCREQ, BUSY, WREADY}
  task automatic chk_ctl(input string nm, input logic [3:0] exp);
    chk(nm, {CDCMASKn, CDCREQ, BUSY, WREADY}, exp);
  endtask

  function automatic logic sig(input int sel);
    return sel == 0 ? CDCREQ : WREADY;
  endfunction

  task automatic wait_until(input string nm, input int sel, input logic val);
    int k = 0;
    while (sig(sel) !== val && k < 2000) begin
      cyc(1);
      k++;
    end
    chk(nm, sig(sel), val);
  endtask

  task automatic send(input logic [31:0] w, input bit push);
    wait_until("send_ready", 1, 1'b1);
    WVALID = 1'b1;
    WDATA  = w;
    if (push) exp_q.push_back(w);
    cyc(1);
    WVALID = 1'b0;
    WDATA  = ~w;
  endtask

  task automatic xfer(input logic [31:0] w, input int d);
    send(w, 1'b1);
    wait_until("xfer_req_hi", 0, 1'b1);
    cyc(d);
    CDCACK = 1'b1;
    wait_until("xfer_req_lo", 0, 1'b0);
    CDCACK = 1'b0;
  endtask

  // receiver model and invariant monitor
  always @(negedge DCLK) begin
    if (!rst_seen) begin
      chk("req_implies_mask", {63'd0, CDCREQ & ~CDCMASKn}, 64'd0);
      if (prev_mask || CDCMASKn) chk("data_stable_open", CDCDATA, prev_data);
    end
    if (CDCREQ && !prev_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_word got=%h want=none", CDCDATA);
      end else chk("rx_word", CDCDATA, exp_q.pop_front());
    end
    chk("absent_outs", {off_data, off_mask, off_req, off_busy, off_rdy}, {32'h0, 4'b0001});
    prev_mask <= CDCMASKn;
    prev_req  <= CDCREQ;
    prev_data <= CDCDATA;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    DRESET = 1'b1; CDCACK = 1'b1; WVALID = 1'b1; WDATA = 32'hFFFFFFFF;
    cyc(3);
    chk("rst_data", CDCDATA, 32'h0);
    chk_ctl("rst_ctl", 4'b0001);
    DRESET = 1'b0; CDCACK = 1'b0; WVALID = 1'b0;
    cyc(1);
    chk_ctl("post_rst_ready", 4'b0001);
    chk("post_rst_data", CDCDATA, 32'h0);

    send(32'hDEADBEEF, 1'b1);
    chk_ctl("t0_load", 4'b0010);
    chk("t0_data", CDCDATA, 32'hDEADBEEF);
    cyc(1);
    chk_ctl("t1_open", 4'b1010);
    cyc(1);
    chk_ctl("t2_req", 4'b1110);
    cyc(3);
    CDCACK = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk_ctl($sformatf("ack_rise_e%0d", k), k < 3 ? 4'b1110 : 4'b0010);
      chk("ack_rise_data", CDCDATA, 32'hDEADBEEF);
    end
    CDCACK = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk_ctl($sformatf("ack_fall_e%0d", k), k < 3 ? 4'b0010 : 4'b0001);
      chk("ack_fall_data", CDCDATA, 32'hDEADBEEF);
    end

    for (int i = 0; i < 100; i++) xfer($urandom, $urandom_range(0, 20));

    send(32'h0BADCAFE, 1'b1);
    wait_until("stall_req", 0, 1'b1);
    for (int k = 0; k < 500; k++) begin
      WVALID = (k % 50) == 7;
      WDATA  = 32'h12345678;
      cyc(1);
      if (k % 100 == 99) begin
        chk_ctl("stall_ctl", 4'b1110);
        chk("stall_data", CDCDATA, 32'h0BADCAFE);
      end
    end
    WVALID = 1'b0;
    CDCACK = 1'b1;
    wait_until("stall_req_lo", 0, 1'b0);
    CDCACK = 1'b0;
    wait_until("stall_done", 1, 1'b1);
    chk("stall_data_end", CDCDATA, 32'h0BADCAFE);

    CDCACK = 1'b1;
    cyc(3);
    send(32'hC0FFEE01, 1'b1);
    chk_ctl("pv_load", 4'b0010);
    cyc(1);
    chk_ctl("pv_open", 4'b1010);
    cyc(1);
    chk_ctl("pv_req", 4'b1110);
    cyc(1);
    chk_ctl("pv_rtz", 4'b0010);
    cyc(5);
    chk_ctl("pv_rtz_hold", 4'b0010);
    CDCACK = 1'b0;
    cyc(2);
    chk_ctl("pv_rtz_e2", 4'b0010);
    cyc(1);
    chk_ctl("pv_idle", 4'b0001);

    for (int s = 1; s <= 4; s++) begin
      held = 32'h11110000 + s;
      send(held, s >= 3);
      if (s >= 2) cyc(s == 2 ? 1 : 2);
      if (s == 4) begin
        CDCACK = 1'b1;
        cyc(3);
      end
      chk_ctl($sformatf("pre_rst_s%0d", s), s == 1 ? 4'b0010 : s == 2 ? 4'b1010 : s == 3 ? 4'b1110 : 4'b0010);
      DRESET = 1'b1;
      CDCACK = 1'b0;
      cyc(1);
      chk_ctl($sformatf("mid_rst_s%0d", s), 4'b0001);
      chk("mid_rst_data", CDCDATA, 32'h0);
      DRESET = 1'b0;
    end
    xfer(32'hA5A5A5A5, 2);
    wait_until("final_idle", 1, 1'b1);
    chk("final_data", CDCDATA, 32'hA5A5A5A5);
    cyc(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
